// File: rtl/am_bip_tx.sv
// Transmit-side BIP insertion for multi-lane PCS alignment markers.
// Each lane keeps an 8-bit running parity that is written into the BIP3/BIP7 bytes of every marker.

module am_bip_lane #(
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid,
    input  logic              marker,
    input  logic [HEAD_W-1:0] head_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o
);
    logic [7:0]        acc;
    logic [7:0]        bp;
    logic [7:0]        acc_nxt;
    logic [DATA_W-1:0] blk;

    always_comb begin
        blk = data_i;
        if (marker) begin
            blk[31:24] = acc;
            blk[63:56] = ~acc;
        end
    end

    // Parity is taken over the block as transmitted, so a marker's own BIP bytes feed the reload.
    always_comb begin
        bp = 8'h00;
        for (int j = 0; j < 8; j++) begin
            for (int m = 0; m < DATA_W / 8; m++) begin
                bp[j] = bp[j] ^ blk[8*m+j];
            end
        end
        bp[3] = bp[3] ^ head_i[0];
        bp[4] = bp[4] ^ head_i[1];
    end

    assign acc_nxt = marker ? bp : (acc ^ bp);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            acc    <= 8'h00;
            head_o <= '0;
            data_o <= '0;
        end else if (valid) begin
            acc    <= acc_nxt;
            head_o <= head_i;
            data_o <= blk;
        end
    end
endmodule

module am_bip_tx #(
    parameter int LANE_N = 4,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic                     valid_i,
    input  logic                     marker_v_i,
    input  logic [LANE_N*HEAD_W-1:0] head_i,
    input  logic [LANE_N*DATA_W-1:0] data_i,
    output logic                     valid_o,
    output logic                     marker_v_o,
    output logic [LANE_N*HEAD_W-1:0] head_o,
    output logic [LANE_N*DATA_W-1:0] data_o
);
    localparam int STAGES = 1;

    logic [STAGES:0]                vld_pipe;
    logic                           mrk;
    logic [LANE_N-1:0][HEAD_W-1:0]  head_v, head_q;
    logic [LANE_N-1:0][DATA_W-1:0]  data_v, data_q;

    assign vld_pipe[0] = valid_i;
    assign mrk         = marker_v_i & valid_i;
    assign head_v      = head_i;
    assign data_v      = data_i;
    assign head_o      = head_q;
    assign data_o      = data_q;
    assign valid_o     = vld_pipe[STAGES];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            vld_pipe[STAGES:1] <= '0;
            marker_v_o         <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (valid_i) marker_v_o <= marker_v_i;
        end
    end

    for (genvar i = 0; i < LANE_N; i++) begin : g_lane
        am_bip_lane #(
            .HEAD_W(HEAD_W),
            .DATA_W(DATA_W)
        ) u_lane (
            .clk    (clk),
            .nreset (nreset),
            .valid  (valid_i),
            .marker (mrk),
            .head_i (head_v[i]),
            .data_i (data_v[i]),
            .head_o (head_q[i]),
            .data_o (data_q[i])
        );
    end
endmodule

// File: tb/tb_am_bip_tx.sv
// Directed and randomised-gap checks of BIP3/BIP7 insertion across four lanes.

module tb_am_bip_tx;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          nreset;
    logic          valid_i;
    logic          marker_v_i;
    logic [LN*2-1:0]  head_i;
    logic [LN*64-1:0] data_i;
    logic          valid_o;
    logic          marker_v_o;
    logic [LN*2-1:0]  head_o;
    logic [LN*64-1:0] data_o;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    am_bip_tx #(.LANE_N(LN), .HEAD_W(2), .DATA_W(64)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .valid_i    (valid_i),
        .marker_v_i (marker_v_i),
        .head_i     (head_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .marker_v_o (marker_v_o),
        .head_o     (head_o),
        .data_o     (data_o)
    );

    always #5 clk = ~clk;

    // Block bit 0/1 are the header, bit k is data[k-2]; bp[j] covers block bits 2+j, 10+j, ...
    function automatic logic [7:0] ref_bp(input logic [1:0] h, input logic [63:0] d);
        logic [65:0] b;
        logic [7:0]  p;
        b = {d, h};
        p = 8'h00;
        for (int k = 2; k < 66; k++) p[3'(k-2)] = p[3'(k-2)] ^ b[k];
        p[3] = p[3] ^ b[0];
        p[4] = p[4] ^ b[1];
        return p;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic m, input logic [LN*2-1:0] h,
                        input logic [LN*64-1:0] d);
        valid_i    = v;
        marker_v_i = m;
        head_i     = h;
        data_i     = d;
        step();
    endtask

    task automatic do_reset;
        nreset = 1'b0;
        send(1'b0, 1'b0, '0, '0);
        step();
        nreset = 1'b1;
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        send(1'b1, 1'b1, '1, '1);
        chk_cnt++;
        if ({valid_o, marker_v_o} !== 2'b00)
            $display("FAIL reset_ctrl: got %b want 00", {valid_o, marker_v_o});
        else pass_cnt++;
        chk_cnt++;
        if (head_o !== '0) $display("FAIL reset_head: got %h want 0", head_o);
        else pass_cnt++;
        chk_cnt++;
        if (data_o !== '0) $display("FAIL reset_data: got %h want 0", data_o);
        else pass_cnt++;
        nreset = 1'b1;
    endtask

    task automatic test_bip_three;
        logic [63:0] exp;
        do_reset();
        for (int n = 0; n < 3; n++) send(1'b1, 1'b0, {LN{2'b01}}, '0);
        send(1'b1, 1'b1, {LN{2'b10}}, {LN{64'h1122334455667788}});
        exp = 64'hF7223344_08667788;
        chk_cnt++;
        if ({valid_o, marker_v_o} !== 2'b11)
            $display("FAIL three_ctrl: got %b want 11", {valid_o, marker_v_o});
        else pass_cnt++;
        chk_cnt++;
        if (head_o !== {LN{2'b10}}) $display("FAIL three_head: got %h want %h", head_o, {LN{2'b10}});
        else pass_cnt++;
        for (int i = 0; i < LN; i++) begin
            chk_cnt++;
            if (data_o[i*64 +: 64] !== exp)
                $display("FAIL three_lane%0d: got %h want %h", i, data_o[i*64 +: 64], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_bip_two;
        logic [63:0] exp;
        do_reset();
        for (int n = 0; n < 2; n++) send(1'b1, 1'b0, {LN{2'b01}}, '0);
        send(1'b1, 1'b1, {LN{2'b10}}, {LN{64'h1122334455667788}});
        exp = 64'hFF223344_00667788;
        for (int i = 0; i < LN; i++) begin
            chk_cnt++;
            if (data_o[i*64 +: 64] !== exp)
                $display("FAIL two_lane%0d: got %h want %h", i, data_o[i*64 +: 64], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_single_lane;
        logic [LN*64-1:0] d;
        logic [63:0]      exp;
        do_reset();
        d = '0;
        d[0] = 1'b1;
        send(1'b1, 1'b0, '0, d);
        send(1'b1, 1'b1, '0, '0);
        for (int i = 0; i < LN; i++) begin
            exp = (i == 0) ? 64'hFE000000_01000000 : 64'hFF000000_00000000;
            chk_cnt++;
            if (data_o[i*64 +: 64] !== exp)
                $display("FAIL single_lane%0d: got %h want %h", i, data_o[i*64 +: 64], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [LN*64-1:0] d;
        logic [63:0]      first [LN];
        logic [63:0]      exp;
        logic [7:0]       p;
        do_reset();
        d = '0;
        for (int i = 0; i < LN; i++) d[i*64 +: 8] = 8'(8'h11 * (i + 1));
        send(1'b1, 1'b1, {LN{2'b01}}, d);
        for (int i = 0; i < LN; i++) begin
            first[i] = d[i*64 +: 64];
            first[i][63:56] = 8'hFF;
            chk_cnt++;
            if (data_o[i*64 +: 64] !== first[i])
                $display("FAIL b2b_first_lane%0d: got %h want %h", i, data_o[i*64 +: 64], first[i]);
            else pass_cnt++;
        end
        send(1'b1, 1'b1, {LN{2'b01}}, d);
        for (int i = 0; i < LN; i++) begin
            p   = ref_bp(2'b01, first[i]);
            exp = d[i*64 +: 64];
            exp[31:24] = p;
            exp[63:56] = ~p;
            chk_cnt++;
            if (data_o[i*64 +: 64] !== exp)
                $display("FAIL b2b_second_lane%0d: got %h want %h", i, data_o[i*64 +: 64], exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_valid_gap;
        logic [7:0]       acc [LN];
        logic [LN*2-1:0]  eh, h;
        logic [LN*64-1:0] ed, d;
        logic [63:0]      blk;
        logic             emv, v, m;
        do_reset();
        for (int i = 0; i < LN; i++) acc[i] = 8'h00;
        eh = '0; ed = '0; emv = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            v = 1'($urandom_range(0, 1));
            m = v ? ($urandom_range(0, 9) == 0) : 1'b1;
            h = 8'($urandom);
            for (int i = 0; i < LN; i++) d[i*64 +: 64] = {$urandom, $urandom};
            if (v) begin
                for (int i = 0; i < LN; i++) begin
                    blk = d[i*64 +: 64];
                    if (m) begin
                        blk[31:24] = acc[i];
                        blk[63:56] = ~acc[i];
                        acc[i] = ref_bp(h[i*2 +: 2], blk);
                    end else begin
                        acc[i] = acc[i] ^ ref_bp(h[i*2 +: 2], blk);
                    end
                    ed[i*64 +: 64] = blk;
                end
                eh  = h;
                emv = m;
            end
            send(v, m, h, d);
            chk_cnt++;
            if (valid_o !== v) $display("FAIL gap_valid n=%0d: got %b want %b", n, valid_o, v);
            else pass_cnt++;
            chk_cnt++;
            if (marker_v_o !== emv) $display("FAIL gap_marker n=%0d: got %b want %b", n, marker_v_o, emv);
            else pass_cnt++;
            chk_cnt++;
            if (head_o !== eh) $display("FAIL gap_head n=%0d: got %h want %h", n, head_o, eh);
            else pass_cnt++;
            chk_cnt++;
            if (data_o !== ed) $display("FAIL gap_data n=%0d: got %h want %h", n, data_o, ed);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        logic [LN*64-1:0] d;
        do_reset();
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < LN; i++) d[i*64 +: 64] = {$urandom, $urandom};
            send(1'b1, 1'b0, 8'($urandom), d);
        end
        nreset = 1'b0;
        send(1'b1, 1'b1, {LN{2'b11}}, '1);
        nreset = 1'b1;
        send(1'b1, 1'b0, {LN{2'b01}}, '0);
        chk_cnt++;
        if ({valid_o, marker_v_o} !== 2'b10)
            $display("FAIL rmid_first_ctrl: got %b want 10", {valid_o, marker_v_o});
        else pass_cnt++;
        send(1'b1, 1'b1, {LN{2'b01}}, '0);
        for (int i = 0; i < LN; i++) begin
            chk_cnt++;
            if (data_o[i*64 +: 64] !== 64'hF7000000_08000000)
                $display("FAIL rmid_lane%0d: got %h want %h", i, data_o[i*64 +: 64], 64'hF7000000_08000000);
            else pass_cnt++;
        end
    endtask

    initial begin
        nreset = 1'b0; valid_i = 1'b0; marker_v_i = 1'b0; head_i = '0; data_i = '0;
        step();
        test_reset();
        test_bip_three();
        test_bip_two();
        test_single_lane();
        test_back_to_back();
        test_valid_gap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/am_bip_tx.md
AM_BIP_TX -- requirements
Module: am_bip_tx

Interface
REQ-001 Parameter LANE_N, default 4, number of PCS lanes.
REQ-002 Parameter HEAD_W, default 2, sync header width per lane.
REQ-003 Parameter DATA_W, default 64, block payload width per lane.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 nreset  input  1  reset, synchronous, active-low.
REQ-006 valid_i  input  1  a block is presented on every lane this cycle.
REQ-007 marker_v_i  input  1  this cycle's blocks are alignment markers (BIP3/BIP7 bytes don't-care).
REQ-008 head_i  input  LANE_N*HEAD_W  sync headers; lane i at [i*HEAD_W +: HEAD_W].
REQ-009 data_i  input  LANE_N*DATA_W  scrambled payloads or marker words; lane i at [i*DATA_W +: DATA_W].
REQ-010 valid_o  output  1  registered copy of valid_i.
REQ-011 marker_v_o  output  1  registered copy of marker_v_i qualified by valid_i.
REQ-012 head_o  output  LANE_N*HEAD_W  registered headers, unmodified.
REQ-013 data_o  output  LANE_N*DATA_W  registered payloads with BIP bytes filled on marker cycles.

Function
REQ-014 Each lane's 66-bit block SHALL be indexed with bit 0 = head[0], bit 1 = head[1], bit k = data[k-2] for k = 2..65.
REQ-015 Per-lane block parity bp[j], j = 0..7, SHALL be the XOR of block bits 2+j, 10+j, ..., 58+j (8 bits); bp[3] additionally XORs bit 0, and bp[4] additionally XORs bit 1.
REQ-016 Each lane SHALL hold an independent 8-bit accumulator acc, reset to 8'h00.
REQ-017 On valid_i=1 and marker_v_i=0, acc SHALL become acc XOR bp(input block), and data is passed unchanged.
REQ-018 On valid_i=1 and marker_v_i=1, the output block SHALL carry data[31:24] = acc (BIP3) and data[63:56] = ~acc (BIP7), with all other bits unchanged.
REQ-019 In the same marker cycle, acc SHALL be reloaded with bp of the transmitted marker block, computed with BIP fields inserted, so the next BIP3 covers the previous marker inclusive.
REQ-020 On valid_i=0, acc SHALL hold, and head_o, data_o and marker_v_o SHALL hold their previous values, with valid_o=0.
REQ-021 marker_v_i while valid_i=0 SHALL be ignored, with no state change.
REQ-022 Latency SHALL be exactly 1 cycle, valid_i to valid_o, with no backpressure; every valid input produces one valid output.
REQ-023 Because BIP7 = ~BIP3 in every marker, the inserted pair's contribution to acc reload SHALL follow REQ-019 literally (no special-casing).
REQ-024 Lanes SHALL be fully independent; lane i's acc depends only on lane i's blocks.
REQ-025 Back-to-back markers (two consecutive valid marker cycles) SHALL be handled: the second BIP3 equals bp of the first transmitted marker.

Reset
REQ-026 While nreset=0 at a clock edge: valid_o=0, marker_v_o=0, head_o=0, data_o=0, all acc=8'h00.
REQ-027 Reset mid-interval SHALL discard the accumulated parity; the first marker after reset covers only blocks accepted since reset release.
REQ-028 The first cycle after reset release SHALL accept input normally.

Verification
REQ-029 Reset, then 3 valid blocks per lane with data=0 and head=2'b01, then a marker -> BIP3=8'h08 and BIP7=8'hF7 on every lane, with other marker bytes passed through.
REQ-030 Reset, then 2 blocks with data=0 and head=2'b01, then a marker -> BIP3=8'h00 and BIP7=8'hFF.
REQ-031 Reset, then 1 block on lane 0 with data=64'h1 (block bit 2) and all other lanes all-zero with head 2'b00, then a marker -> lane 0 BIP3=8'h01 and BIP7=8'hFE; lanes 1-3 BIP3=8'h00.
REQ-032 Two consecutive markers with no data in between -> second marker's BIP3 equals the reference-model parity of the first transmitted marker, per lane.
REQ-033 valid_i toggled 1/0 randomly over 1000 blocks with marker_v_i asserted on invalid cycles -> acc and outputs unaffected by invalid cycles, matching a reference model fed only valid blocks; valid_o trails valid_i by exactly 1 cycle.
REQ-034 Assert nreset between markers after 5 blocks, release, send 1 block with data=0 and head=2'b01, then a marker -> BIP3=8'h08.
